// File: rtl/down_counter_ctrl.sv
// -----------------------------------------------------------------------------
// down_counter_ctrl
//
// Purpose:
//   Loadable down-counter with a start/pause/abort control FSM. After a start
//   is accepted, count decrements once every PRESCALE clock cycles until it
//   reaches zero. The FSM then spends one cycle in DONE, where done is high.
//
// Parameters:
//   WIDTH    - width of load_val and count, in bits (default 4)
//   PRESCALE - clk cycles per decrement tick, 1..255 (default 1)
//
// Optional feature:
//   AUTO_RELOAD_EN - when defined, adds input auto_reload. With auto_reload
//                    high in DONE, the counter reloads load_val and runs again.
//
// Ports:
//   clk         in   rising-edge clock
//   reset       in   synchronous, active-low reset
//   auto_reload in   restart from DONE (present only with AUTO_RELOAD_EN)
//   load_val    in   start value, sampled when start is accepted in IDLE
//   start       in   begin a countdown; has an effect only in IDLE
//   pause       in   level-sensitive hold while counting
//   abort       in   cancel the countdown; the highest-priority control
//   count       out  registered counter value
//   busy        out  high in RUN and PAUSE
//   paused      out  high in PAUSE
//   done        out  high for the single cycle the FSM is in DONE
//   state_dbg   out  raw FSM state, for debug and checkers
//
// Handshake: there is no valid/ready pairing. start is a request that is
//   accepted on any rising edge where the FSM is in IDLE and is silently
//   dropped otherwise. pause and abort are levels sampled on every edge.
// -----------------------------------------------------------------------------
module down_counter_ctrl #(
    parameter int WIDTH    = 4,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             reset,
`ifdef AUTO_RELOAD_EN
    input  logic             auto_reload,
`endif
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             pause,
    input  logic             abort,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             paused,
    output logic             done,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [7:0]       PRESC_LAST = 8'(PRESCALE - 1);
    localparam logic [WIDTH-1:0] CNT_ZERO   = '0;
    localparam logic [WIDTH-1:0] CNT_ONE    = WIDTH'(1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [7:0]       presc_q, presc_d;

    // Result of one counting cycle (prescaler advance, possibly a tick).
    logic             tick;
    logic             step_finish;
    logic [7:0]       step_presc;
    logic [WIDTH-1:0] step_count;

    logic             reload_req;

    always_comb begin
        tick        = (presc_q == PRESC_LAST);
        step_presc  = tick ? 8'd0 : presc_q + 8'd1;
        // count is never 0 while counting; the <= guard keeps it from wrapping.
        step_finish = tick && (count_q <= CNT_ONE);
        step_count  = count_q;
        if (tick) begin
            step_count = step_finish ? CNT_ZERO : count_q - CNT_ONE;
        end
    end

`ifdef AUTO_RELOAD_EN
    assign reload_req = auto_reload;
`else
    assign reload_req = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        presc_d = presc_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    count_d = load_val;
                    presc_d = 8'd0;
                    state_d = (load_val == CNT_ZERO) ? ST_DONE : ST_RUN;
                end
            end

            ST_RUN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    count_d = CNT_ZERO;
                    presc_d = 8'd0;
                end else if (pause) begin
                    // Frozen: the tick that would fire this cycle is dropped.
                    state_d = ST_PAUSE;
                end else begin
                    count_d = step_count;
                    presc_d = step_presc;
                    state_d = step_finish ? ST_DONE : ST_RUN;
                end
            end

            ST_PAUSE: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    count_d = CNT_ZERO;
                    presc_d = 8'd0;
                end else if (!pause) begin
                    // The release cycle is already a counting cycle, so the
                    // countdown slips by exactly the number of cycles pause
                    // was sampled high. A tick here can finish the count.
                    count_d = step_count;
                    presc_d = step_presc;
                    state_d = step_finish ? ST_DONE : ST_RUN;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
                if (abort) begin
                    count_d = CNT_ZERO;
                    presc_d = 8'd0;
                end else if (reload_req) begin
                    count_d = load_val;
                    presc_d = 8'd0;
                    state_d = (load_val == CNT_ZERO) ? ST_IDLE : ST_RUN;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            count_q <= CNT_ZERO;
            presc_q <= 8'd0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            presc_q <= presc_d;
        end
    end

    assign count     = count_q;
    assign busy      = (state_q == ST_RUN) || (state_q == ST_PAUSE);
    assign paused    = (state_q == ST_PAUSE);
    assign done      = (state_q == ST_DONE);
    assign state_dbg = state_q;

endmodule

// File: tb/tb_down_counter_ctrl.sv
// -----------------------------------------------------------------------------
// tb_down_counter_ctrl
//
// Two instances share one set of inputs: dut1 (PRESCALE=1) and dut3
// (PRESCALE=3). A vector table and hand-written sequences exercise the fixed
// scenarios; a randomized phase compares both instances against a reference
// model that tracks only "counting cycles remaining" and derives count from it.
// -----------------------------------------------------------------------------
module tb_down_counter_ctrl;

    localparam int W = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset    = 1'b0;
    logic         start    = 1'b0;
    logic         pause    = 1'b0;
    logic         abort    = 1'b0;
    logic [W-1:0] load_val = '0;
    bit           ar       = 1'b0;
`ifdef AUTO_RELOAD_EN
    logic         auto_reload;
    assign auto_reload = ar;
`endif

    logic [W-1:0] count1, count3;
    logic         busy1, paused1, done1;
    logic         busy3, paused3, done3;
    logic [1:0]   st1, st3;

    down_counter_ctrl #(.WIDTH(W), .PRESCALE(1)) dut1 (
        .clk        (clk),
        .reset      (reset),
`ifdef AUTO_RELOAD_EN
        .auto_reload(auto_reload),
`endif
        .load_val   (load_val),
        .start      (start),
        .pause      (pause),
        .abort      (abort),
        .count      (count1),
        .busy       (busy1),
        .paused     (paused1),
        .done       (done1),
        .state_dbg  (st1)
    );

    down_counter_ctrl #(.WIDTH(W), .PRESCALE(3)) dut3 (
        .clk        (clk),
        .reset      (reset),
`ifdef AUTO_RELOAD_EN
        .auto_reload(auto_reload),
`endif
        .load_val   (load_val),
        .start      (start),
        .pause      (pause),
        .abort      (abort),
        .count      (count3),
        .busy       (busy3),
        .paused     (paused3),
        .done       (done3),
        .state_dbg  (st3)
    );

    // ---------------- scoreboard bookkeeping ----------------
    int n_cmp  = 0;
    int n_fail = 0;
    logic [W+2:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic r, input logic s, input logic p, input logic a,
                         input logic [W-1:0] ld);
        reset = r; start = s; pause = p; abort = a; load_val = ld;
    endtask

    // Advance one edge; outputs are sampled 1 time unit after it.
    task automatic tick_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic check1(input string tag, input int c, input bit b, input bit p, input bit d);
        check($sformatf("%s count", tag),  count1,  c);
        check($sformatf("%s busy", tag),   busy1,   b);
        check($sformatf("%s paused", tag), paused1, p);
        check($sformatf("%s done", tag),   done1,   d);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic         rst_n, st, pa, ab;
        logic [W-1:0] ld;
        int           e_count;
        bit           e_busy, e_paused, e_done;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input bit r, input bit s, input bit p, input bit a,
                                input int ld, input int c, input bit b,
                                input bit pz, input bit d);
        vec_t v;
        v.rst_n = r; v.st = s; v.pa = p; v.ab = a; v.ld = W'(ld);
        v.e_count = c; v.e_busy = b; v.e_paused = pz; v.e_done = d;
        return v;
    endfunction

    // ---------------- reference model ----------------
    // A countdown is a budget of load*PRESCALE counting cycles; the visible
    // count is the number of whole-or-partial ticks still outstanding.
    int pres[2] = '{1, 3};
    int m_rem[2];
    bit m_act[2], m_pau[2], m_done[2];

    task automatic model_edge(input int i);
        if (!reset) begin
            m_act[i] = 0; m_pau[i] = 0; m_done[i] = 0; m_rem[i] = 0;
        end else if (m_done[i]) begin
            m_done[i] = 0;
            if (!abort && ar && load_val != 0) begin
                m_act[i] = 1; m_pau[i] = 0; m_rem[i] = int'(load_val) * pres[i];
            end
        end else if (m_act[i]) begin
            if (abort) begin
                m_act[i] = 0; m_pau[i] = 0; m_rem[i] = 0;
            end else if (pause) begin
                m_pau[i] = 1;
            end else begin
                m_pau[i] = 0;
                m_rem[i]--;
                if (m_rem[i] == 0) begin
                    m_act[i] = 0; m_done[i] = 1;
                end
            end
        end else if (start) begin
            if (load_val == 0) begin
                m_done[i] = 1;
            end else begin
                m_act[i] = 1; m_pau[i] = 0; m_rem[i] = int'(load_val) * pres[i];
            end
        end
    endtask

    function automatic logic [W+2:0] model_out(input int i);
        int c;
        c = m_act[i] ? (m_rem[i] + pres[i] - 1) / pres[i] : 0;
        return {W'(c), m_act[i], m_act[i] & m_pau[i], m_done[i]};
    endfunction

    // ---------------- test sequence ----------------
    initial begin
        logic [W+2:0] exp_v;
        int exp_c[7];
        bit exp_d[7];

        // Reset, start/ignore, load 0, abort-with-pause, pause/resume, abort in PAUSE.
        vecs.push_back(mk(0,0,0,0,0, 0,0,0,0));
        vecs.push_back(mk(1,0,0,0,0, 0,0,0,0));
        vecs.push_back(mk(1,1,0,0,5, 5,1,0,0));
        vecs.push_back(mk(1,0,0,0,5, 4,1,0,0));
        vecs.push_back(mk(1,0,0,0,5, 3,1,0,0));
        vecs.push_back(mk(1,0,0,0,5, 2,1,0,0));
        vecs.push_back(mk(1,0,0,0,5, 1,1,0,0));
        vecs.push_back(mk(1,0,0,0,5, 0,0,0,1));
        vecs.push_back(mk(1,0,0,0,5, 0,0,0,0));
        vecs.push_back(mk(1,1,0,0,0, 0,0,0,1));
        vecs.push_back(mk(1,1,0,0,0, 0,0,0,0));
        vecs.push_back(mk(1,0,0,0,0, 0,0,0,0));
        vecs.push_back(mk(1,1,0,0,9, 9,1,0,0));
        vecs.push_back(mk(1,1,0,0,3, 8,1,0,0));
        vecs.push_back(mk(1,0,0,0,3, 7,1,0,0));
        vecs.push_back(mk(1,0,0,0,3, 6,1,0,0));
        vecs.push_back(mk(1,0,0,0,3, 5,1,0,0));
        vecs.push_back(mk(1,0,0,0,3, 4,1,0,0));
        vecs.push_back(mk(1,0,1,1,3, 0,0,0,0));
        vecs.push_back(mk(1,0,0,0,3, 0,0,0,0));
        vecs.push_back(mk(1,1,0,0,3, 3,1,0,0));
        vecs.push_back(mk(1,0,1,0,3, 3,1,1,0));
        vecs.push_back(mk(1,0,1,0,3, 3,1,1,0));
        vecs.push_back(mk(1,0,0,0,3, 2,1,0,0));
        vecs.push_back(mk(1,0,0,0,3, 1,1,0,0));
        vecs.push_back(mk(1,0,0,0,3, 0,0,0,1));
        vecs.push_back(mk(1,0,0,0,3, 0,0,0,0));
        vecs.push_back(mk(1,1,0,0,4, 4,1,0,0));
        vecs.push_back(mk(1,0,1,0,4, 4,1,1,0));
        vecs.push_back(mk(1,0,1,1,4, 0,0,0,0));
        vecs.push_back(mk(1,0,0,0,4, 0,0,0,0));

        foreach (vecs[k]) begin
            drive(vecs[k].rst_n, vecs[k].st, vecs[k].pa, vecs[k].ab, vecs[k].ld);
            tick_edge();
            check1($sformatf("vec%0d", k), vecs[k].e_count, vecs[k].e_busy,
                   vecs[k].e_paused, vecs[k].e_done);
        end

        // Reset mid-countdown at count=3, then start on the first edge after release.
        drive(1,1,0,0,6); tick_edge();
        check("rst_seq load count", count1, 6);
        drive(1,0,0,0,6);
        for (int k = 0; k < 3; k++) tick_edge();
        check("rst_seq pre-reset count", count1, 3);
        drive(0,0,0,0,6); tick_edge();
        check1("rst_seq in reset", 0, 0, 0, 0);
        drive(1,1,0,0,2); tick_edge();
        check1("rst_seq restart", 2, 1, 0, 0);
        drive(1,0,0,0,2); tick_edge();
        check1("rst_seq c1", 1, 1, 0, 0);
        tick_edge();
        check1("rst_seq done", 0, 0, 0, 1);
        tick_edge();
        check1("rst_seq idle", 0, 0, 0, 0);

        // PRESCALE=3, load 2, pause high on the 5th..8th edges after start.
        drive(0,0,0,0,0); tick_edge();
        drive(1,1,0,0,2); tick_edge();
        check("p3 load count", count3, 2);
        check("p3 load busy", busy3, 1);
        drive(1,0,0,0,2);
        for (int k = 1; k <= 10; k++) begin
            pause = (k >= 5 && k <= 8);
            tick_edge();
            check($sformatf("p3 e%0d count", k), count3, (k < 3) ? 2 : (k < 10) ? 1 : 0);
            check($sformatf("p3 e%0d paused", k), paused3, (k >= 5 && k <= 8));
            check($sformatf("p3 e%0d done", k), done3, (k == 10));
        end
        pause = 0;
        tick_edge();
        check("p3 after busy", busy3, 0);
        check("p3 after done", done3, 0);

`ifdef AUTO_RELOAD_EN
        // Auto-reload with load 2: 2,1,0,2,1,0,2 then drop auto_reload.
        exp_c = '{2,1,0,2,1,0,2};
        exp_d = '{0,0,1,0,0,1,0};
        drive(0,0,0,0,2); tick_edge();
        ar = 1;
        drive(1,1,0,0,2);
        for (int k = 0; k < 7; k++) begin
            tick_edge();
            start = 0;
            check($sformatf("ar e%0d count", k), count1, exp_c[k]);
            check($sformatf("ar e%0d done", k), done1, exp_d[k]);
        end
        ar = 0;
        tick_edge(); check("ar drop c1", count1, 1);
        tick_edge(); check("ar drop done", done1, 1);
        tick_edge(); check("ar drop idle busy", busy1, 0);
        check("ar drop idle count", count1, 0);
`else
        exp_c = '{0,0,0,0,0,0,0};
        exp_d = '{0,0,0,0,0,0,0};
`endif

        // Randomized phase against the reference model, both instances.
        drive(0,0,0,0,0);
        for (int k = 0; k < 800; k++) begin
            if (k > 0) begin
                reset    = ($urandom_range(0, 99) != 0);
                start    = ($urandom_range(0, 3) == 0);
                pause    = ($urandom_range(0, 4) == 0);
                abort    = ($urandom_range(0, 24) == 0);
                load_val = $urandom_range(0, 1) ? W'($urandom_range(0, 3))
                                                : W'($urandom_range(0, 15));
`ifdef AUTO_RELOAD_EN
                ar       = ($urandom_range(0, 1) == 1);
`endif
            end
            model_edge(0);
            model_edge(1);
            exp_q.push_back(model_out(0));
            exp_q.push_back(model_out(1));
            tick_edge();
            exp_v = exp_q.pop_front();
            check($sformatf("rnd%0d dut1", k), {count1, busy1, paused1, done1}, exp_v);
            exp_v = exp_q.pop_front();
            check($sformatf("rnd%0d dut3", k), {count3, busy3, paused3, done3}, exp_v);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/down_counter_ctrl.md
DOWN_COUNTER_CTRL -- requirements
Module: down_counter_ctrl

Interface
REQ-001 Parameter WIDTH, default 4: count and load_val width in bits.
REQ-002 Parameter PRESCALE, default 1: clk cycles per decrement tick, range 1..255.
REQ-003 Port clk, input, 1: the single clock; all state updates on the rising edge.
REQ-004 Port reset, input, 1: synchronous, active-low reset.
REQ-005 Port load_val, input, WIDTH: start value, sampled when start is accepted.
REQ-006 Port start, input, 1: request to begin a countdown.
REQ-007 Port pause, input, 1: level-sensitive hold request.
REQ-008 Port abort, input, 1: cancel the countdown.
REQ-009 Port count, output, WIDTH: current counter value, registered.
REQ-010 Port busy, output, 1: high in states RUN and PAUSE.
REQ-011 Port paused, output, 1: high in state PAUSE only.
REQ-012 Port done, output, 1: single-cycle completion pulse.

Function
REQ-013 FSM SHALL have four states, IDLE, RUN, PAUSE and DONE, encoded in 2 bits.
REQ-014 IDLE: count holds; start=1 loads count<=load_val and enters RUN, or enters DONE directly if load_val==0.
REQ-015 start SHALL be ignored in every state except IDLE.
REQ-016 An internal prescaler 0..PRESCALE-1 SHALL clear on each IDLE->RUN entry; tick fires on the cycle where prescaler==PRESCALE-1.
REQ-017 RUN tick: count<=count-1; if count==1, count<=0 and next state is DONE.
REQ-018 Priority in RUN and PAUSE SHALL be abort > pause > tick.
REQ-019 abort=1 in RUN, PAUSE or DONE: next state IDLE, count<=0, no done pulse.
REQ-020 RUN with pause=1: enter PAUSE; count and prescaler are frozen and the tick in that cycle is suppressed.
REQ-021 PAUSE with pause=0: return to RUN; the prescaler resumes from its frozen value.
REQ-022 done=1 exactly while state==DONE.
REQ-023 DONE SHALL last one cycle, then go to IDLE (see REQ-029 for the alternative).
REQ-024 Latency: if start is accepted at edge N with load_val=V>0 and no pause, DONE is entered at edge N+V*PRESCALE.
REQ-025 count SHALL never wrap below 0 and never exceed the loaded value.

Reset
REQ-026 reset==0 at a rising edge SHALL set state=IDLE, count=0, prescaler=0, busy=0, paused=0, done=0; reset overrides all other inputs.
REQ-027 Reset asserted mid-countdown SHALL abandon the countdown with no done pulse; after release, start is accepted on the first edge.

Configuration
REQ-028 Macro AUTO_RELOAD_EN, when defined, SHALL add input port auto_reload (1 bit).
REQ-029 With AUTO_RELOAD_EN and auto_reload=1 in DONE: count<=load_val, prescaler<=0, next state RUN; if load_val==0, next state IDLE instead. If auto_reload=0, next state IDLE.
REQ-030 Without AUTO_RELOAD_EN: port auto_reload is absent; DONE always returns to IDLE.

Verification
REQ-031 PRESCALE=1, load_val=5, start pulse at edge N -> count 5,4,3,2,1,0 at edges N..N+5; done=1 only in the cycle after edge N+5; busy=0 after edge N+6.
REQ-032 load_val=0, start -> DONE next edge; done pulses once; count stays 0; busy never asserts.
REQ-033 PRESCALE=3, load_val=2, pause high for 4 cycles starting mid-count -> count frozen during pause; done arrives 4 cycles later than the no-pause run (edge N+6+4).
REQ-034 load_val=9, abort at count=4 with pause also high -> IDLE, count=0, no done pulse; start raised during RUN before abort is ignored.
REQ-035 reset driven low at count=3 -> count=0, state IDLE at the next edge; a start on the first edge after release is accepted normally.
REQ-036 AUTO_RELOAD_EN defined, auto_reload=1, load_val=2 -> count 2,1,0,2,1,0...; done pulses every 3 cycles; dropping auto_reload returns the FSM to IDLE after the next done pulse.
